// File: rtl/dmem_arbiter_if.sv
// Requester/dmem bus shared by the two dmem ports and the data memory.
// The slave modport is the arbiter's view; master is the environment's view.
interface dmem_arbiter_if #(
   parameter int DWIDTH = 4
);
   logic [1:0]        req;
   logic [1:0]        we;
   logic [DWIDTH-1:0] adr0;
   logic [DWIDTH-1:0] adr1;
   logic [DWIDTH-1:0] wd0;
   logic [DWIDTH-1:0] wd1;
   logic [1:0]        gnt;
   logic [1:0]        rvalid;
   logic [DWIDTH-1:0] rdata;
   logic              mem_we;
   logic [DWIDTH-1:0] mem_adr;
   logic [DWIDTH-1:0] mem_wd;
   logic [DWIDTH-1:0] mem_rd;

   modport slave (
      input  req, we, adr0, adr1, wd0, wd1, mem_rd,
      output gnt, rvalid, rdata, mem_we, mem_adr, mem_wd
   );

   modport master (
      output req, we, adr0, adr1, wd0, wd1, mem_rd,
      input  gnt, rvalid, rdata, mem_we, mem_adr, mem_wd
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port dmem between the CPU (port 0) and
// the loader/debug port (port 1), with a bounded burst and registered read return.
module dmem_arbiter #(
   parameter int DWIDTH    = 4,
   parameter int MAX_BURST = 4
) (
   input  logic           clk,
   input  logic           reset,
   dmem_arbiter_if.slave  bus
);

   localparam int             CW        = $clog2(MAX_BURST + 1);
   localparam logic [CW-1:0]  BURST_MAX = CW'(MAX_BURST);
   localparam logic [CW-1:0]  BURST_ONE = CW'(1);

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      SERVE = 1'b1
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic              owner_r;
   logic              owner_nxt_s;
   logic              last_r;
   logic              last_nxt_s;
   logic [CW-1:0]     burst_cnt_r;
   logic [CW-1:0]     burst_nxt_s;
   logic [1:0]        rvalid_r;
   logic [DWIDTH-1:0] rdata_r;

   logic              req_own_s;
   logic              req_oth_s;
   logic [1:0]        gnt_s;
   logic              mem_we_s;
   logic [DWIDTH-1:0] mem_adr_s;
   logic [DWIDTH-1:0] mem_wd_s;

   function automatic logic [1:0] port_onehot(input logic port);
      return port ? 2'b10 : 2'b01;
   endfunction

   // Dmem pins and grant follow the owner's live inputs while serving.
   always_comb begin
      gnt_s     = 2'b00;
      mem_we_s  = 1'b0;
      mem_adr_s = '0;
      mem_wd_s  = '0;
      if (state_r == SERVE) begin
         gnt_s     = port_onehot(owner_r);
         mem_we_s  = bus.we[owner_r];
         mem_adr_s = owner_r ? bus.adr1 : bus.adr0;
         mem_wd_s  = owner_r ? bus.wd1  : bus.wd0;
      end else begin
         gnt_s     = 2'b00;
         mem_we_s  = 1'b0;
      end
   end

   // Next-state logic: selection from IDLE, burst accounting and hand-over in SERVE.
   always_comb begin
      state_nxt_s = state_r;
      owner_nxt_s = owner_r;
      last_nxt_s  = last_r;
      burst_nxt_s = burst_cnt_r;
      req_own_s   = bus.req[owner_r];
      req_oth_s   = bus.req[~owner_r];
      case (state_r)
         IDLE: begin
            if (bus.req != 2'b00) begin
               state_nxt_s = SERVE;
               burst_nxt_s = BURST_ONE;
               // On a tie the port that was not served last wins.
               if (bus.req == 2'b11) begin
                  owner_nxt_s = ~last_r;
               end else begin
                  owner_nxt_s = bus.req[1];
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         SERVE: begin
            if (req_oth_s && (!req_own_s || (burst_cnt_r == BURST_MAX))) begin
               owner_nxt_s = ~owner_r;
               burst_nxt_s = BURST_ONE;
               last_nxt_s  = owner_r;
            end else if (req_own_s) begin
               if (burst_cnt_r != BURST_MAX) begin
                  burst_nxt_s = burst_cnt_r + BURST_ONE;
               end else begin
                  burst_nxt_s = BURST_MAX;
               end
            end else begin
               state_nxt_s = IDLE;
               last_nxt_s  = owner_r;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Arbitration state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r     <= IDLE;
         owner_r     <= 1'b0;
         last_r      <= 1'b1;
         burst_cnt_r <= '0;
      end else begin
         state_r     <= state_nxt_s;
         owner_r     <= owner_nxt_s;
         last_r      <= last_nxt_s;
         burst_cnt_r <= burst_nxt_s;
      end
   end

   // Read return: capture dmem data at the end of a granted read.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rvalid_r <= 2'b00;
         rdata_r  <= '0;
      end else if ((state_r == SERVE) && !bus.we[owner_r]) begin
         rvalid_r <= port_onehot(owner_r);
         rdata_r  <= bus.mem_rd;
      end else begin
         rvalid_r <= 2'b00;
         rdata_r  <= rdata_r;
      end
   end

   assign bus.gnt     = gnt_s;
   assign bus.mem_we  = mem_we_s;
   assign bus.mem_adr = mem_adr_s;
   assign bus.mem_wd  = mem_wd_s;
   assign bus.rvalid  = rvalid_r;
   assign bus.rdata   = rdata_r;

endmodule
